// File: rtl/h14tx_decoding_terc4_island_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : h14tx_decoding_terc4_island_pkg
//  Description : Shared types and constants for the TERC4 data-island path.
//                Holds the lane symbol/nibble types, the 16-entry TERC4 code
//                table (index = 4-bit data value), the channel 1/2 data-island
//                guard-band symbol and the island framer state type.
//  Revision    : 1.0 - initial release
// ============================================================================
package h14tx_decoding_terc4_island_pkg;

  typedef logic [9:0] symbol_t;   // lane symbol, bit 0 transmitted first
  typedef logic [3:0] data_t;     // decoded nibble

  // TERC4 code words, indexed by the 4-bit value they carry.
  localparam symbol_t TERC4_CODE [0:15] = '{
    10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
    10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
    10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
    10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
  };

  // Data-island guard-band symbol on TMDS channels 1 and 2.
  localparam symbol_t DI_GUARD_CH12 = 10'b0100110011;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LEAD   = 2'd1,
    ISLAND = 2'd2,
    TRAIL  = 2'd3
  } island_state_e;

endpackage : h14tx_decoding_terc4_island_pkg
`default_nettype wire

// File: rtl/h14tx_decoding_terc4_island_if.sv
`default_nettype none
// ============================================================================
//  Module      : h14tx_decoding_terc4_island_if
//  Description : Symbol-in / nibble-out bundle of the TERC4 island decoder.
//                master : symbol source (drives symbol_valid, symbol,
//                         err_clear; observes the decoded outputs)
//                slave  : the decoder
//  Revision    : 1.0 - initial release
// ============================================================================
interface h14tx_decoding_terc4_island_if #(
  parameter int ERR_W = 16
);
  import h14tx_decoding_terc4_island_pkg::*;

  logic             symbol_valid;
  symbol_t          symbol;
  logic             err_clear;
  logic             data_valid;
  data_t            data;
  logic             pkt_start;
  logic             island_active;
  logic             sym_err;
  logic [ERR_W-1:0] err_count;

  modport master (
    output symbol_valid, symbol, err_clear,
    input  data_valid, data, pkt_start, island_active, sym_err, err_count
  );

  modport slave (
    input  symbol_valid, symbol, err_clear,
    output data_valid, data, pkt_start, island_active, sym_err, err_count
  );

endinterface : h14tx_decoding_terc4_island_if
`default_nettype wire

// File: rtl/h14tx_decoding_terc4_island_lookup.sv
`default_nettype none
// ============================================================================
//  Module      : h14tx_decoding_terc4_island_lookup
//  Description : Combinational TERC4 inverse lookup. Searches the shared code
//                table so encoder and decoder can never disagree.
//  Ports       : i_symbol  - 10-bit lane symbol
//                o_hit     - symbol is one of the 16 TERC4 code words
//                o_nibble  - carried value (0 when o_hit is low)
//  Revision    : 1.0 - initial release
// ============================================================================
module h14tx_decoding_terc4_island_lookup
  import h14tx_decoding_terc4_island_pkg::*;
(
  input  symbol_t i_symbol,
  output logic    o_hit,
  output data_t   o_nibble
);

  always_comb begin
    o_hit    = 1'b0;
    o_nibble = '0;
    for (int i = 0; i < 16; i++) begin
      if (i_symbol == TERC4_CODE[i]) begin
        o_hit    = 1'b1;
        o_nibble = data_t'(i);
      end
    end
  end

endmodule : h14tx_decoding_terc4_island_lookup
`default_nettype wire

// File: rtl/h14tx_decoding_terc4_island.sv
`default_nettype none
// ============================================================================
//  Module      : h14tx_decoding_terc4_island
//  Description : Single-lane TERC4 receive decoder and data-island framer for
//                TMDS channel 1/2. Recognises the two-symbol lead guard band,
//                decodes 32-symbol packet slots, closes on the trail guard
//                band and flags/counts framing and code errors.
//  Ports       : clk, rst_n (async, active low)
//                io_bus.symbol_valid/symbol/err_clear   - inputs
//                io_bus.data_valid/data/pkt_start       - decoded nibble stream
//                io_bus.island_active/sym_err/err_count - status
//                All outputs registered, 1 cycle after the accepted symbol.
//  Revision    : 1.0 - initial release
// ============================================================================
module h14tx_decoding_terc4_island
  import h14tx_decoding_terc4_island_pkg::*;
#(
  parameter symbol_t GUARD_SYMBOL = DI_GUARD_CH12,
  parameter int      MAX_PACKETS  = 18,
  parameter int      ERR_W        = 16
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  h14tx_decoding_terc4_island_if.slave         io_bus
);

  localparam int              PKT_W      = $clog2(MAX_PACKETS + 1);
  localparam logic [PKT_W-1:0] C_LAST_PKT = PKT_W'(MAX_PACKETS - 1);

  island_state_e    r_state, w_state_nxt;
  logic [4:0]       r_slot,  w_slot_nxt;
  logic [PKT_W-1:0] r_pkt,   w_pkt_nxt;

  logic             r_data_valid, r_pkt_start, r_island_active, r_sym_err;
  data_t            r_data;
  logic [ERR_W-1:0] r_err_count;

  logic             w_hit;
  data_t            w_nibble;
  logic             w_is_guard;
  logic             w_dv, w_ps, w_err, w_ia;
  data_t            w_data;

  h14tx_decoding_terc4_island_lookup u_lookup (
    .i_symbol (io_bus.symbol),
    .o_hit    (w_hit),
    .o_nibble (w_nibble)
  );

  assign w_is_guard = (io_bus.symbol == GUARD_SYMBOL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_slot  <= '0;
      r_pkt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_slot  <= w_slot_nxt;
      r_pkt   <= w_pkt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_slot_nxt  = r_slot;
    w_pkt_nxt   = r_pkt;
    w_dv        = 1'b0;
    w_ps        = 1'b0;
    w_err       = 1'b0;
    w_data      = '0;
    // island_active follows the decoded stream: it stays up across idle
    // (symbol_valid=0) cycles inside the island but drops on the cycle that
    // reports the closing guard symbol.
    w_ia        = (r_state == ISLAND);

    if (io_bus.symbol_valid) begin
      unique case (r_state)
        IDLE: begin
          if (w_is_guard) w_state_nxt = LEAD;
        end
        LEAD: begin
          // A lone guard symbol is line noise, not a framing error.
          if (w_is_guard) begin
            w_state_nxt = ISLAND;
            w_slot_nxt  = '0;
            w_pkt_nxt   = '0;
          end else begin
            w_state_nxt = IDLE;
          end
        end
        ISLAND: begin
          if (w_is_guard) begin
            // Only a guard on a packet boundary after at least one full
            // packet is a clean end of island.
            w_err       = !((r_slot == 5'd0) && (r_pkt != '0));
            w_ia        = 1'b0;
            w_state_nxt = TRAIL;
          end else begin
            w_dv       = 1'b1;
            w_ps       = (r_slot == 5'd0);
            w_err      = !w_hit;
            w_data     = w_hit ? w_nibble : data_t'(0);
            w_slot_nxt = r_slot + 5'd1;
            if (r_slot == 5'd31) begin
              w_pkt_nxt = r_pkt + PKT_W'(1);
              if (r_pkt == C_LAST_PKT) w_state_nxt = TRAIL;
            end
          end
        end
        TRAIL: begin
          w_err       = !w_is_guard;
          w_state_nxt = IDLE;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data_valid    <= 1'b0;
      r_data          <= '0;
      r_pkt_start     <= 1'b0;
      r_island_active <= 1'b0;
      r_sym_err       <= 1'b0;
      r_err_count     <= '0;
    end else begin
      r_data_valid    <= w_dv;
      r_data          <= w_data;
      r_pkt_start     <= w_ps;
      r_island_active <= w_ia;
      r_sym_err       <= w_err;
      // Clear wins over an error reported in the same cycle.
      if (io_bus.err_clear) begin
        r_err_count <= '0;
      end else if (w_err && (r_err_count != '1)) begin
        r_err_count <= r_err_count + ERR_W'(1);
      end
    end
  end

  assign io_bus.data_valid    = r_data_valid;
  assign io_bus.data          = r_data;
  assign io_bus.pkt_start     = r_pkt_start;
  assign io_bus.island_active = r_island_active;
  assign io_bus.sym_err       = r_sym_err;
  assign io_bus.err_count     = r_err_count;

endmodule : h14tx_decoding_terc4_island
`default_nettype wire
